vector_mm_control_unit: RTL
===========================

Name: vector_mm_control_unit

Overview:
- Parametrised multicycle control FSM for the memory-to-memory vector processor.
- Decodes an 8+ bit opcode by class and drives datapath selects and strobes.
- Handshakes every memory access with mem_ready.
- Adds a vector class that repeats one M-type element operation vec_len times, with an element counter.
- Sits between the instruction register and the datapath muxes, ALU and memory.

Parameters:
OP_W, 8, opcode width; must be >= 8. op[OP_W-1:OP_W-3] is the class, op[3:0] is the sub-op.
ALUOP_W, 4, aluOp width; must be 4 or 5; aluOp is taken from op[ALUOP_W-1:0] in compute states.
VLEN_W, 6, width of vec_len and elem_idx; maximum vector length is 2^VLEN_W-1.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
op  in  OP_W  opcode from the instruction register
mem_ready  in  1  memory completed the current request this cycle
vec_len  in  VLEN_W  element count; sampled in V_SETUP
mem_req  out  1  memory access request
irWrite  out  1  load instruction register
pcSrc  out  2  0 = ALU, 1 = branch target, 2 = jump target, 3 = register
writeMemDst  out  2  memory write address select
writeDataSrc  out  2  memory write data select
memWrite  out  1  memory write strobe
aluOp  out  ALUOP_W  ALU function
aluSrcA  out  2  ALU A select
aluSrcB  out  2  ALU B select
readSrc  out  1  memory read address select; 0 = PC
pcWrite  out  1  unconditional PC write
pcWriteCond  out  1  PC write if ALU zero
writeRa  out  1  return address register write
writeSp  out  1  stack pointer write
illegal_op  out  1  one-cycle pulse when DECODE sees a reserved opcode
halted  out  1  high while in HALT
elem_idx  out  VLEN_W  current vector element index
current_state  out  4  registered state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, M_EXEC=2, B_EXEC=3, I_EXEC=4, LD_EXEC=5, J_EXEC=6, V_SETUP=7, V_ELEM=8, HALT=9, FAULT=10. Codes 11..15 go to FETCH.
- Reset: while reset=0, state=FETCH, elem_idx=0, len_q=0, and every output is 0 (strobes are gated by reset). The first fetch request follows release on the next clock.
- Defaults every cycle: all strobes 0, all selects 0, aluOp=0. Only the settings listed per state differ.
- FETCH:
  - mem_req=1, readSrc=0, aluSrcA=0, aluSrcB=2, aluOp=0.
  - When mem_ready=1: irWrite=1 and pcWrite=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
- DECODE: aluSrcA=1, aluSrcB=2 (branch target precompute). Next state by class op[OP_W-1:OP_W-3]:
  - 000 -> M_EXEC
  - 001 -> B_EXEC
  - 010 -> I_EXEC
  - 011 -> LD_EXEC
  - 100 -> J_EXEC
  - 101 -> V_SETUP
  - 110 -> FETCH with illegal_op=1
  - 111 -> HALT
- M_EXEC: aluSrcA=1, aluSrcB=0, aluOp=op sub, memWrite=1, writeMemDst=1, writeDataSrc=0, mem_req=1. Hold until mem_ready, then FETCH.
- B_EXEC: aluSrcA=1, aluSrcB=0, aluOp=1 (SUB), pcWriteCond=1, pcSrc=1. Single cycle, then FETCH.
- I_EXEC: aluSrcA=1, aluSrcB=2, aluOp=op sub, memWrite=1, writeMemDst=0, writeDataSrc=1, mem_req=1. Hold until mem_ready, then FETCH.
- LD_EXEC, by op[1:0]:
  - 00 ld: memWrite=1, mem_req=1, writeMemDst=0, writeDataSrc=1; waits for mem_ready.
  - 01 li: same as ld but writeDataSrc=3; waits for mem_ready.
  - 10 lr: writeRa=1; single cycle.
  - 11 allofree: aluSrcA=1, writeSp=1; single cycle.
  - Then FETCH.
- J_EXEC, pcWrite=1 plus, by op[1:0]:
  - 00 j: pcSrc=2
  - 01 jal: pcSrc=2, writeRa=1
  - 10 jr: pcSrc=3
  - 11 reserved: no pcWrite, illegal_op=1
  - Single cycle, then FETCH.
- V_SETUP: len_q <= vec_len, elem_idx <= 0. If vec_len==0 -> FETCH (see Optional Feature). Otherwise -> V_ELEM.
- V_ELEM:
  - Outputs as M_EXEC, plus elem_idx drives the datapath offset.
  - On mem_ready: if elem_idx==len_q-1, go to FETCH and reset elem_idx to 0. Otherwise elem_idx increments and stay.
  - elem_idx never wraps; len_q is held constant during the loop even if vec_len changes.
- HALT: halted=1, all strobes 0. Left only by reset.
- FAULT: all strobes 0. Left only by reset.
- mem_ready outside a requesting state is ignored.
- Asynchronous reset mid-loop aborts the loop; no further memWrite.

Optional Feature:
- Macro: VMCU_ZERO_LEN_FAULT_EN.
- Defined: V_SETUP with vec_len==0 goes to FAULT, and illegal_op pulses for one cycle in V_SETUP.
- Undefined: a zero-length vector instruction is a one-cycle no-op returning to FETCH.

Test Plan:
- Reset held 3 cycles, mem_ready=1 -> all outputs 0 during reset; after release FETCH asserts mem_req, irWrite, pcWrite; state goes 0 -> 1.
- op=8'h00 (M-type), mem_ready low 2 cycles in M_EXEC -> memWrite=1, writeMemDst=1 held 3 cycles, then FETCH.
- op=8'hA3, vec_len=4, mem_ready always 1 -> 4 V_ELEM cycles with elem_idx 0,1,2,3, aluOp=3, then FETCH and elem_idx=0.
- op=8'h81 (jal) -> J_EXEC one cycle with pcWrite=1, pcSrc=2, writeRa=1. op=8'h82 (jr) -> pcSrc=3.
- op=8'hC0 -> illegal_op pulse of exactly 1 cycle, back to FETCH. op=8'hE0 -> halted=1 stuck until reset.
- op=8'hA0 with vec_len=0 -> FETCH next cycle with macro off; FAULT plus illegal_op pulse with VMCU_ZERO_LEN_FAULT_EN.

Source files
------------

// File: rtl/vector_mm_control_unit.sv
// Multicycle control FSM for the memory-to-memory vector processor, including a vector element loop.
// Optional build macro VMCU_ZERO_LEN_FAULT_EN: a zero-length vector instruction traps to FAULT.
module vector_mm_control_unit #(
    parameter int OP_W    = 8,
    parameter int ALUOP_W = 4,
    parameter int VLEN_W  = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    input  logic [VLEN_W-1:0]  vec_len,
    output logic               mem_req,
    output logic               irWrite,
    output logic [1:0]         pcSrc,
    output logic [1:0]         writeMemDst,
    output logic [1:0]         writeDataSrc,
    output logic               memWrite,
    output logic [ALUOP_W-1:0] aluOp,
    output logic [1:0]         aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic               readSrc,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               writeRa,
    output logic               writeSp,
    output logic               illegal_op,
    output logic               halted,
    output logic [VLEN_W-1:0]  elem_idx,
    output logic [3:0]         current_state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        M_EXEC  = 4'd2,
        B_EXEC  = 4'd3,
        I_EXEC  = 4'd4,
        LD_EXEC = 4'd5,
        J_EXEC  = 4'd6,
        V_SETUP = 4'd7,
        V_ELEM  = 4'd8,
        HALT    = 4'd9,
        FAULT   = 4'd10
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [VLEN_W-1:0]   len_q;
    logic [VLEN_W-1:0]   elem_q;
    logic [2:0]          op_class;
    logic [ALUOP_W-1:0]  sub_alu;
    logic                last_elem;
    logic                zero_len;
    logic                unused_op_bits;

    assign op_class       = op[OP_W-1 -: 3];
    assign sub_alu        = op[ALUOP_W-1:0];
    assign last_elem      = (elem_q == len_q - VLEN_W'(1));
    assign zero_len       = (vec_len == '0);
    assign unused_op_bits = &{1'b0, op};

    assign elem_idx      = elem_q;
    assign current_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    // len_q is latched once per vector instruction so vec_len may change mid-loop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            len_q  <= '0;
            elem_q <= '0;
        end else begin
            case (state)
                V_SETUP: begin
                    len_q  <= vec_len;
                    elem_q <= '0;
                end
                V_ELEM: begin
                    if (mem_ready) begin
                        elem_q <= last_elem ? '0 : elem_q + VLEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   if (mem_ready) next_state = DECODE;
            DECODE: begin
                case (op_class)
                    3'b000:  next_state = M_EXEC;
                    3'b001:  next_state = B_EXEC;
                    3'b010:  next_state = I_EXEC;
                    3'b011:  next_state = LD_EXEC;
                    3'b100:  next_state = J_EXEC;
                    3'b101:  next_state = V_SETUP;
                    3'b110:  next_state = FETCH;
                    default: next_state = HALT;
                endcase
            end
            M_EXEC,
            I_EXEC:  if (mem_ready) next_state = FETCH;
            B_EXEC,
            J_EXEC:  next_state = FETCH;
            LD_EXEC: if (op[1] || mem_ready) next_state = FETCH;
            V_SETUP: begin
                if (zero_len) begin
`ifdef VMCU_ZERO_LEN_FAULT_EN
                    next_state = FAULT;
`else
                    next_state = FETCH;
`endif
                end else begin
                    next_state = V_ELEM;
                end
            end
            V_ELEM:  if (mem_ready && last_elem) next_state = FETCH;
            HALT:    next_state = HALT;
            FAULT:   next_state = FAULT;
            default: next_state = FETCH;
        endcase
    end

    // Everything is forced low while reset is asserted, even though the state reads FETCH.
    always_comb begin
        mem_req      = 1'b0;
        irWrite      = 1'b0;
        pcSrc        = '0;
        writeMemDst  = '0;
        writeDataSrc = '0;
        memWrite     = 1'b0;
        aluOp        = '0;
        aluSrcA      = '0;
        aluSrcB      = '0;
        readSrc      = 1'b0;
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        writeRa      = 1'b0;
        writeSp      = 1'b0;
        illegal_op   = 1'b0;
        halted       = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    aluSrcB = 2'd2;
                    irWrite = mem_ready;
                    pcWrite = mem_ready;
                end
                DECODE: begin
                    aluSrcA    = 2'd1;
                    aluSrcB    = 2'd2;
                    illegal_op = (op_class == 3'b110);
                end
                M_EXEC, V_ELEM: begin
                    aluSrcA     = 2'd1;
                    aluOp       = sub_alu;
                    memWrite    = 1'b1;
                    writeMemDst = 2'd1;
                    mem_req     = 1'b1;
                end
                B_EXEC: begin
                    aluSrcA     = 2'd1;
                    aluOp       = ALUOP_W'(1);
                    pcWriteCond = 1'b1;
                    pcSrc       = 2'd1;
                end
                I_EXEC: begin
                    aluSrcA      = 2'd1;
                    aluSrcB      = 2'd2;
                    aluOp        = sub_alu;
                    memWrite     = 1'b1;
                    writeDataSrc = 2'd1;
                    mem_req      = 1'b1;
                end
                LD_EXEC: begin
                    case (op[1:0])
                        2'b00: begin
                            memWrite     = 1'b1;
                            mem_req      = 1'b1;
                            writeDataSrc = 2'd1;
                        end
                        2'b01: begin
                            memWrite     = 1'b1;
                            mem_req      = 1'b1;
                            writeDataSrc = 2'd3;
                        end
                        2'b10: writeRa = 1'b1;
                        default: begin
                            aluSrcA = 2'd1;
                            writeSp = 1'b1;
                        end
                    endcase
                end
                J_EXEC: begin
                    case (op[1:0])
                        2'b00: begin
                            pcWrite = 1'b1;
                            pcSrc   = 2'd2;
                        end
                        2'b01: begin
                            pcWrite = 1'b1;
                            pcSrc   = 2'd2;
                            writeRa = 1'b1;
                        end
                        2'b10: begin
                            pcWrite = 1'b1;
                            pcSrc   = 2'd3;
                        end
                        default: illegal_op = 1'b1;
                    endcase
                end
                V_SETUP: begin
`ifdef VMCU_ZERO_LEN_FAULT_EN
                    illegal_op = zero_len;
`endif
                end
                HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
